// File: rtl/pipeline_irq_ctrl.sv
// Interrupt controller feeding the MIPS core's coproc0 interrupt input: edge capture, mask, fixed priority, ack + hold-off.
// Optional IRQ_CTRL_SYNC_EN adds a 2-flop synchroniser on every request line ahead of edge detection.
module pipeline_irq_ctrl #(
  parameter int               N_IRQ       = 8,
  parameter int               IDW         = 3,
  parameter int               HOLDOFF_CYC = 2,
  parameter logic [N_IRQ-1:0] MASK_RST    = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic             i_we,
  input  logic [1:0]       i_addr,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata,
  input  logic             i_ack,
  output logic             o_interrupt,
  output logic [IDW-1:0]   o_irq_id,
  output logic [1:0]       o_dbg_state
);

  // Interface contract: i_ack is a single-cycle pulse and is only honoured in ASSERT;
  // o_interrupt is a registered level that stays high until ack or a W1C of the served bit.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  state_e           state_q;
  logic [IDW-1:0]   id_q;
  logic             irq_q;
  logic [7:0]       cnt_q;
  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_q, mask_d;

  logic [N_IRQ-1:0] irq_s;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] req;
  logic [N_IRQ-1:0] w1c_clr;
  logic [N_IRQ-1:0] ack_clr;
  logic [IDW-1:0]   pick_id;
  logic             w1c_hit;
  logic             ack_fire;
  logic             w1c_served;
  logic [31:0]      unused_wdata;

`ifdef IRQ_CTRL_SYNC_EN
  logic [N_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_irq;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = i_irq;
`endif

  assign unused_wdata = i_wdata;
  assign rise         = irq_s & ~prev_q;
  assign req          = pending_q & mask_q;
  assign w1c_hit      = i_we && (i_addr == 2'd0);
  assign w1c_clr      = w1c_hit ? i_wdata[N_IRQ-1:0] : '0;
  assign ack_fire     = (state_q == ST_ASSERT) && i_ack;
  assign w1c_served   = (state_q == ST_ASSERT) && w1c_hit && i_wdata[id_q];
  assign mask_d       = (i_we && (i_addr == 2'd1)) ? i_wdata[N_IRQ-1:0] : mask_q;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      ack_clr[i] = ack_fire && (id_q == IDW'(i));
    end
  end

  // Clear first, then OR in new edges so a coincident edge keeps the bit set.
  assign pending_d = (pending_q & ~(w1c_clr | ack_clr)) | rise;

  // Fixed priority: lowest index wins.
  always_comb begin
    pick_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) pick_id = IDW'(i);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_q    <= '0;
      pending_q <= '0;
      mask_q    <= MASK_RST;
    end else begin
      prev_q    <= irq_s;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      irq_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            id_q    <= pick_id;
            irq_q   <= 1'b1;
            state_q <= ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          if (ack_fire) begin
            irq_q <= 1'b0;
            if (HOLDOFF_CYC == 0) begin
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_HOLDOFF;
              cnt_q   <= 8'(HOLDOFF_CYC - 1);
            end
          end else if (w1c_served) begin
            // Software withdrew the served request: drop straight to IDLE, no gap.
            irq_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_HOLDOFF: begin
          if (cnt_q == 8'd0) state_q <= ST_IDLE;
          else               cnt_q   <= cnt_q - 8'd1;
        end
        default: begin
          irq_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_addr)
      2'd0: o_rdata[N_IRQ-1:0] = pending_q;
      2'd1: o_rdata[N_IRQ-1:0] = mask_q;
      2'd2: if (state_q == ST_ASSERT) o_rdata[IDW-1:0] = id_q;
      default: o_rdata = '0;
    endcase
  end

  assign o_interrupt = irq_q;
  assign o_irq_id    = id_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_pipeline_irq_ctrl.sv
// Bench for pipeline_irq_ctrl: fixed vector table, hand-written corner sequences, then random traffic
// against a behavioural model of the controller.
module tb_pipeline_irq_ctrl;

  localparam int         N    = 8;
  localparam int         IDW  = 3;
  localparam int         HOLD = 2;
  localparam logic [7:0] MRST = 8'h00;
`ifdef IRQ_CTRL_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   irq;
  logic           we;
  logic [1:0]     addr;
  logic [31:0]    wdata;
  logic [31:0]    rdata;
  logic           ack;
  logic           interrupt;
  logic [IDW-1:0] irq_id;
  logic [1:0]     dbg_state;

  int checks   = 0;
  int failures = 0;

  pipeline_irq_ctrl #(
    .N_IRQ(N), .IDW(IDW), .HOLDOFF_CYC(HOLD), .MASK_RST(MRST)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_irq(irq), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .o_rdata(rdata), .i_ack(ack), .o_interrupt(interrupt),
    .o_irq_id(irq_id), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model: pending/mask as bit sets, "serving" flag, and a gap countdown of idle cycles.
  logic [7:0] m_pend, m_mask, m_prev, m_sh0, m_sh1;
  bit         m_serving;
  int         m_id;
  int         m_gap;

  task automatic model_reset();
    m_pend = '0; m_mask = MRST; m_prev = '0; m_sh0 = '0; m_sh1 = '0;
    m_serving = 0; m_id = 0; m_gap = 0;
  endtask

  task automatic model_step();
    logic [7:0] s, rises, clr, old_pend;
    if (SL == 0) s = irq;
    else s = m_sh1;
    m_sh1 = m_sh0;
    m_sh0 = irq;
    rises  = s & ~m_prev;
    m_prev = s;
    old_pend = m_pend;
    clr = (we && addr == 2'd0) ? wdata[7:0] : 8'h00;
    if (m_serving) begin
      if (ack) begin
        clr = clr | (8'h01 << m_id);
        m_serving = 0;
        m_gap = HOLD;
      end else if (we && addr == 2'd0 && wdata[m_id]) begin
        m_serving = 0;
        m_gap = 0;
      end
    end else if (m_gap > 0) begin
      m_gap = m_gap - 1;
    end else if ((old_pend & m_mask) != 0) begin
      for (int i = N - 1; i >= 0; i--) if (old_pend[i] && m_mask[i]) m_id = i;
      m_serving = 1;
    end
    if (we && addr == 2'd1) m_mask = wdata[7:0];
    m_pend = (old_pend & ~clr) | rises;
  endtask

  function automatic logic [31:0] m_rdata();
    case (addr)
      2'd0:    return {24'h0, m_pend};
      2'd1:    return {24'h0, m_mask};
      2'd2:    return m_serving ? 32'(m_id) : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    irq = '0; we = 0; addr = 2'd0; wdata = '0; ack = 0;
  endtask

  // One clock: model advances on the same edge, outputs sampled 1 ns later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("model_interrupt", 32'(interrupt), 32'(m_serving));
    chk("model_irq_id", 32'(irq_id), 32'(m_id));
    chk("model_rdata", rdata, m_rdata());
  endtask

  typedef struct {
    logic [7:0]  irq;
    logic        we;
    logic [1:0]  addr;
    logic [7:0]  wdata;
    logic        ack;
    logic        e_int;
    logic [2:0]  e_id;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl[27];

  initial begin
    // Scenario 1: single source, latency, ACTIVE_ID of id 0, ack + hold-off.
    tbl[0]  = '{8'h00, 1'b1, 2'd1, 8'h01, 1'b0, 1'b0, 3'd0, 32'h01};
    tbl[1]  = '{8'h01, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 3'd0, 32'h01};
    tbl[2]  = '{8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 3'd0, 32'h01};
    tbl[3]  = '{8'h00, 1'b0, 2'd2, 8'h00, 1'b0, 1'b1, 3'd0, 32'h00};
    tbl[4]  = '{8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 3'd0, 32'h00};
    tbl[5]  = '{8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 3'd0, 32'h00};
    tbl[6]  = '{8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 3'd0, 32'h00};
    tbl[7]  = '{8'h00, 1'b0, 2'd3, 8'h00, 1'b0, 1'b0, 3'd0, 32'h00};
    // Scenario 2: sources 5 and 2 together; 2 first, then 5 after HOLD+1 low cycles.
    tbl[8]  = '{8'h00, 1'b1, 2'd1, 8'hFF, 1'b0, 1'b0, 3'd0, 32'hFF};
    tbl[9]  = '{8'h24, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 3'd0, 32'h24};
    tbl[10] = '{8'h24, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 3'd2, 32'h24};
    tbl[11] = '{8'h00, 1'b0, 2'd2, 8'h00, 1'b0, 1'b1, 3'd2, 32'h02};
    tbl[12] = '{8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 3'd2, 32'h20};
    tbl[13] = '{8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 3'd2, 32'h20};
    tbl[14] = '{8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 3'd2, 32'h20};
    tbl[15] = '{8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 3'd5, 32'h20};
    tbl[16] = '{8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 3'd5, 32'h00};
    tbl[17] = '{8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 3'd5, 32'h00};
    tbl[18] = '{8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 3'd5, 32'h00};
    tbl[19] = '{8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 3'd5, 32'h00};
    // Scenario 3: masked source stays pending, unmasking raises the level next edge; W1C withdraws it.
    tbl[20] = '{8'h00, 1'b1, 2'd1, 8'h00, 1'b0, 1'b0, 3'd5, 32'h00};
    tbl[21] = '{8'h08, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 3'd5, 32'h08};
    tbl[22] = '{8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 3'd5, 32'h08};
    tbl[23] = '{8'h00, 1'b1, 2'd1, 8'h08, 1'b0, 1'b0, 3'd5, 32'h08};
    tbl[24] = '{8'h00, 1'b0, 2'd2, 8'h00, 1'b0, 1'b1, 3'd3, 32'h03};
    tbl[25] = '{8'h00, 1'b1, 2'd0, 8'h08, 1'b0, 1'b0, 3'd3, 32'h00};
    tbl[26] = '{8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 3'd3, 32'h00};

    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("reset_interrupt", 32'(interrupt), 32'h0);
    chk("reset_irq_id", 32'(irq_id), 32'h0);
    chk("reset_pending", rdata, 32'h0);
    addr = 2'd1;
    #1;
    chk("reset_mask", rdata, 32'(MRST));
    addr = 2'd0;
    #9;
    rst_n = 1'b1;

    for (int r = 0; r < 27; r++) begin
      irq = tbl[r].irq; we = tbl[r].we; addr = tbl[r].addr;
      wdata = {24'hA5A5A5, tbl[r].wdata}; ack = tbl[r].ack;
      cycle();
      chk($sformatf("vec%0d_interrupt", r), 32'(interrupt), 32'(tbl[r].e_int));
      chk($sformatf("vec%0d_irq_id", r), 32'(irq_id), 32'(tbl[r].e_id));
      chk($sformatf("vec%0d_rdata", r), rdata, tbl[r].e_rdata);
    end
    idle_inputs();

    // Scenario 4: W1C of the served bit (id 1) drops to IDLE without hold-off.
    we = 1; addr = 2'd1; wdata = 32'hFF; cycle();
    idle_inputs(); irq = 8'h02; cycle();
    irq = 8'h00; cycle();
    chk("s4_interrupt_on", 32'(interrupt), 32'h1);
    chk("s4_id", 32'(irq_id), 32'h1);
    we = 1; addr = 2'd0; wdata = 32'h02; cycle();
    chk("s4_interrupt_off", 32'(interrupt), 32'h0);
    chk("s4_pending", rdata, 32'h0);
    chk("s4_state_idle", 32'(dbg_state), 32'h0);
    idle_inputs(); cycle();
    chk("s4_stays_low", 32'(interrupt), 32'h0);

    // Scenario 5: ack coincident with a new edge on the served line keeps it pending.
    irq = 8'h10; cycle();
    irq = 8'h00; cycle();
    chk("s5_id", 32'(irq_id), 32'h4);
    irq = 8'h10; ack = 1; cycle();
    chk("s5_interrupt_off", 32'(interrupt), 32'h0);
    chk("s5_pending_kept", rdata, 32'h10);
    idle_inputs();
    for (int i = 0; i < HOLD; i++) begin
      cycle();
      chk("s5_holdoff_low", 32'(interrupt), 32'h0);
    end
    cycle();
    chk("s5_reassert", 32'(interrupt), 32'h1);
    chk("s5_reassert_id", 32'(irq_id), 32'h4);
    ack = 1; cycle();
    idle_inputs();
    repeat (HOLD + 2) cycle();

    // Scenario 6: asynchronous reset while the level is high.
    irq = 8'h01; cycle();
    irq = 8'h00; cycle();
    chk("s6_interrupt_on", 32'(interrupt), 32'h1);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("s6_interrupt_async", 32'(interrupt), 32'h0);
    chk("s6_irq_id_async", 32'(irq_id), 32'h0);
    chk("s6_pending_async", rdata, 32'h0);
    addr = 2'd1;
    #1;
    chk("s6_mask_async", rdata, 32'(MRST));
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    we = 1; addr = 2'd1; wdata = 32'hFF; cycle();
    idle_inputs();

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      irq   = 8'($urandom) & 8'($urandom) & 8'($urandom);
      we    = ($urandom_range(0, 7) == 0);
      addr  = 2'($urandom_range(0, 3));
      wdata = $urandom;
      ack   = ($urandom_range(0, 3) == 0);
      cycle();
    end
    idle_inputs();
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
